sram_arbiter: RTL
=================

# sram_arbiter

Two-port controller that shares the single-ported SRAM2 data memory between the instruction-fetch path (port 0) and the load/store path (port 1). Each access is sequenced onto the SRAM's OE/RW/CS/address pins and its shared 32-bit tristate data bus, and write data is driven onto that bus. Read data is captured, already sign-extended by the memory, and returned to the granted requester. The block sits between the pipeline's memory stages and SRAM2.

## Interface
- ADDR_W, 11, SRAM word address width
- DATA_W, 16, stored word width
- BUS_W, 32, SRAM data bus width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this edge when valid&ready
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  in  ADDR_W  word address
- p0_req_wdata / p1_req_wdata  in  DATA_W  write data
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- p0_rsp_rdata / p1_rsp_rdata  out  BUS_W  read data; holds last value otherwise
- sram_addr  out  ADDR_W  to SRAM address
- sram_oe  out  1  to SRAM OE (0 = read)
- sram_rw  out  1  to SRAM RW (1 with OE=1 = write)
- sram_cs  out  1  to SRAM CS, active-low during access
- sram_data  inout  BUS_W  shared data bus

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR.
- IDLE: grant computed combinationally from valids and priority pointer; ready = (state==IDLE) && granted. On accept: register addr, we, wdata, and port id; go to RD_ADDR (read) or WR (write).
- RD_ADDR: oe=0, rw=0, cs=0, addr driven. SRAM latches the word at the closing edge. Go to RD_DATA.
- RD_DATA: same pin values. SRAM drives the bus. Controller captures sram_data into that port's rdata register at the closing edge. Go to IDLE.
- WR: oe=1, rw=1, cs=0. sram_data driven = {16'b0, wdata}. SRAM writes at the closing edge. Go to IDLE.
- rsp_valid for the owning port pulses in the cycle after RD_DATA or WR. This is an IDLE cycle, so a new accept may occur in the same cycle.
- Bus drive rule: controller drives sram_data only in WR; high-Z in all other states and during reset. Contention is impossible because the SRAM drives only when oe=0.
- Non-accepted requester must hold its request stable. No queueing, no cancellation.

## Timing
- Reset values: state=IDLE, sram_oe=1, sram_rw=0, sram_cs=1, sram_addr=0, sram_data=Z, all ready=0, rsp_valid=0, rdata=0, priority pointer=port 0.
- Reset mid-operation: access aborted immediately, bus released, no rsp_valid issued. A write in WR may or may not land; this is not guaranteed.
- Read: accept edge E0; RD_ADDR during E0→E1; RD_DATA during E1→E2; rsp_valid high E2→E3. Latency is 3 cycles, and a read occupies 3 cycles including the response/IDLE cycle.
- Write: accept E0; WR E0→E1; rsp_valid E1→E2. Latency is 2 cycles.
- Sustained throughput: one read per 3 cycles, one write per 2 cycles.
- Simultaneous valids: the winner is chosen per Configuration; the loser stalls with ready=0.
- Address range 0..2047; no wrap or bounds logic, since the address is passed through.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. The pointer flips to the other port after every accept. The first contention after reset goes to port 0.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins. The pointer register is removed.

## Structure
- Shared package sram_ctrl_pkg: state encoding (IDLE, RD_ADDR, RD_DATA, WR), ADDR_W/DATA_W/BUS_W defaults, port id constants.
- One sub-module, arb_2way: combinational 2-requester grant plus priority pointer, with the macro applied there.

## Test plan
- Reset: assert rst_n=0 mid-WR → oe=1, rw=0, cs=1, bus Z, no rsp_valid; after release, state IDLE.
- P1 write addr 5 data 16'h8001, then P0 read addr 5 → p0_rsp_rdata=32'hFFFF8001, 3 cycles after the accept.
- P0 write addr 2047 data 16'h007F, then read back → rdata=32'h0000007F; write rsp_valid 2 cycles after accept.
- Both valid every cycle, reads to addr 1 and 2, RR build → grants alternate P0,P1,P0,P1; fixed build → P0 only, P1 ready stays 0.
- Back-to-back: read addr 3 then write addr 3 accepted in the read's response cycle → no X on sram_data, write lands, next read returns new value.
- Bus monitor throughout: sram_data driven by the controller only when oe=1 and rw=1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM2 two-port controller: sequencer states,
// default bus widths and requester ids.
package sram_ctrl_pkg;
    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_BUS_W  = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LDST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;
endpackage

// File: rtl/sram_arbiter_arb_2way.sv
// Two-requester grant logic. Define SRAM_ARB_RR_EN for round-robin,
// otherwise port 0 has fixed priority and no pointer state exists.
module arb_2way
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);
`ifdef SRAM_ARB_RR_EN
    logic ptr;

    // Pointer names the port that wins the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= PORT_FETCH;
        else if (accept)
            ptr <= ~ptr;
    end

    always_comb begin
        grant = 2'b00;
        if (ptr == PORT_FETCH) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end else begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end
    end
`else
    logic unused;
    assign unused = ^{clk, rst_n, accept};

    always_comb begin
        grant = 2'b00;
        if (valid[0])      grant = 2'b01;
        else if (valid[1]) grant = 2'b10;
    end
`endif
endmodule

// File: rtl/sram_arbiter.sv
// Shares single-ported SRAM2 between fetch (port 0) and load/store (port 1).
// Arbitration mode is selected by SRAM_ARB_RR_EN (see arb_2way).
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int BUS_W  = SRAM_BUS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [BUS_W-1:0]  p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [BUS_W-1:0]  p1_rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe,
    output logic              sram_rw,
    output logic              sram_cs,
    inout  wire  [BUS_W-1:0]  sram_data
);
    state_t            state;
    logic [1:0]        valid, grant, ready, rspValid;
    logic              acceptAny, selPort, selWe, portQ, busDrv;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata, wdataQ;
    logic [BUS_W-1:0]  rdata0Q, rdata1Q;

    assign valid = {p1_req_valid, p0_req_valid};

    arb_2way uArb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .accept (acceptAny),
        .grant  (grant)
    );

    assign ready        = (state == IDLE && rst_n) ? grant : 2'b00;
    assign acceptAny    = |(ready & valid);
    assign p0_req_ready = ready[0];
    assign p1_req_ready = ready[1];

    assign selPort  = grant[1];
    assign selWe    = selPort ? p1_req_we    : p0_req_we;
    assign selAddr  = selPort ? p1_req_addr  : p0_req_addr;
    assign selWdata = selPort ? p1_req_wdata : p0_req_wdata;

    // Only the WR state drives the bus; the SRAM drives it only while OE is low.
    assign sram_data = busDrv ? {{(BUS_W-DATA_W){1'b0}}, wdataQ} : 'z;

    assign p0_rsp_valid = rspValid[0];
    assign p1_rsp_valid = rspValid[1];
    assign p0_rsp_rdata = rdata0Q;
    assign p1_rsp_rdata = rdata1Q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            portQ     <= PORT_FETCH;
            wdataQ    <= '0;
            busDrv    <= 1'b0;
            rspValid  <= 2'b00;
            rdata0Q   <= '0;
            rdata1Q   <= '0;
            sram_addr <= '0;
            sram_oe   <= 1'b1;
            sram_rw   <= 1'b0;
            sram_cs   <= 1'b1;
        end else begin
            rspValid <= 2'b00;
            case (state)
                IDLE: begin
                    if (acceptAny) begin
                        portQ     <= selPort;
                        sram_addr <= selAddr;
                        wdataQ    <= selWdata;
                        sram_cs   <= 1'b0;
                        if (selWe) begin
                            state   <= WR;
                            sram_oe <= 1'b1;
                            sram_rw <= 1'b1;
                            busDrv  <= 1'b1;
                        end else begin
                            state   <= RD_ADDR;
                            sram_oe <= 1'b0;
                            sram_rw <= 1'b0;
                        end
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    state   <= IDLE;
                    sram_oe <= 1'b1;
                    sram_cs <= 1'b1;
                    if (portQ) rdata1Q <= sram_data;
                    else       rdata0Q <= sram_data;
                    rspValid[portQ] <= 1'b1;
                end
                WR: begin
                    state   <= IDLE;
                    sram_rw <= 1'b0;
                    sram_cs <= 1'b1;
                    busDrv  <= 1'b0;
                    rspValid[portQ] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
